radix2_div: RTL
===============

# radix2_div

Iterative radix-2 restoring divider that sits behind the divide-stream interface used by the execute-stage multiply/divide unit. It replaces the vendor divider core: it has the same dividend/divisor/dout stream ports, so a `div` (SIGNED=1) or `divu` (SIGNED=0) instance drops in unchanged. It takes one dividend/divisor pair at a time and returns `{quotient, remainder}` a fixed WIDTH+2 cycles after acceptance. It holds that result stable until the next operation overwrites it.

## Interface
- SIGNED, 1, 1 = two's-complement divide (MIPS DIV); 0 = unsigned divide (DIVU)
- WIDTH, 32, operand width; dout is 2*WIDTH
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears the block
- s_axis_dividend_tvalid  in  1  dividend valid
- s_axis_dividend_tready  out  1  dividend ready
- s_axis_dividend_tdata  in  WIDTH  dividend
- s_axis_divisor_tvalid  in  1  divisor valid
- s_axis_divisor_tready  out  1  divisor ready
- s_axis_divisor_tdata  in  WIDTH  divisor
- m_axis_dout_tvalid  out  1  one-cycle result-valid pulse
- m_axis_dout_tdata  out  2*WIDTH  `{quotient[WIDTH-1:0], remainder[WIDTH-1:0]}`

## Operation
- **States:** IDLE, BUSY, FIX.
- **Ready:** both tready outputs are identical. They equal `(state==IDLE) && reset`.
- **Accept:** happens on a rising edge in IDLE only when both tvalid and both tready are 1.
  - If only one tvalid is high, nothing is accepted and no data is captured.
  - The inputs are not required to be held after acceptance.
- **On accept, capture:**
  - sign flags: dividend sign, and whether the operand signs differ (zero when SIGNED=0);
  - absolute values of both operands, taken as unsigned WIDTH bits, so `|0x80000000| = 0x80000000`;
  - a divide-by-zero flag;
  - the raw dividend;
  - iteration counter = 0.
- **State transitions:** accept moves IDLE→BUSY.
- **BUSY, one iteration per cycle for WIDTH cycles:**
  - Shift `{partial_rem, quotient_shift}` left by one.
  - Form a trial value: the (WIDTH+1)-bit partial remainder minus `{0, |divisor|}`.
  - If the trial value is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After iteration count WIDTH-1, move BUSY→FIX.
- **FIX, one cycle, then back to IDLE:**
  - quotient = negate(q) if the operand signs differ, else q;
  - remainder = negate(r) if the dividend is negative, else r;
  - the result is written to the m_axis_dout_tdata register;
  - m_axis_dout_tvalid is registered to 1 for the following cycle only.
- **Divide by zero:** quotient = all ones and remainder = raw dividend, for both SIGNED values.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. No exception is raised.
- **No backpressure on dout:**
  - m_axis_dout_tvalid is a single-cycle pulse and has no tready.
  - m_axis_dout_tdata holds its value until the FIX cycle of the next accepted operation.
- **Cancellation is the consumer's job:** the block has no flush input. A consumer cancels by ignoring the next dout_tvalid pulse.

## Timing
- **Cycle numbering:** cycle 0 is the handshake cycle.
- **Per-cycle schedule:**
  - cycles 1..WIDTH: BUSY, tready = 0;
  - cycle WIDTH+1: FIX, tready = 0;
  - cycle WIDTH+2: m_axis_dout_tvalid = 1, state is IDLE, tready = 1.
- **Latency:** 34 cycles for WIDTH=32.
- **Back-to-back:** a new operation may be accepted in the same cycle as the dout_tvalid pulse. Throughput is one operation per WIDTH+2 cycles.
- **Values after reset:**
  - state = IDLE, counter = 0;
  - m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0;
  - both tready = 0 while reset==0, and 1 in the first cycle after reset deasserts.
- **Reset mid-operation (BUSY or FIX):**
  - the in-flight operation is aborted and no dout_tvalid pulse is produced for it;
  - dout_tdata is cleared to 0.
- **Reset in the cycle of a dout_tvalid pulse:** the pulse is still visible in that cycle. It is cleared on the edge.

## Test plan
- **Signed basics,** SIGNED=1:
  - 7/2 → dout 0x00000003_00000001, dout_tvalid exactly 34 cycles after the handshake;
  - −7/2 (0xFFFFFFF9/0x00000002) → 0xFFFFFFFD_FFFFFFFF;
  - 7/−2 → 0xFFFFFFFD_00000001.
- **Unsigned,** SIGNED=0: 0xFFFFFFFF/0x00000010 → 0x0FFFFFFF_0000000F. The same operands with SIGNED=1 → 0x00000000_FFFFFFFF.
- **Corner values:**
  - divide by zero, 0x12345678/0 → 0xFFFFFFFF_12345678 for both SIGNED values;
  - 0x80000000/0xFFFFFFFF with SIGNED=1 → 0x80000000_00000000.
- **Handshake rules:**
  - dividend_tvalid=1 with divisor_tvalid=0 for 10 cycles → no dout_tvalid ever, tready stays 1;
  - tvalid held high through BUSY → tready stays 0 and only one result is produced.
- **Back-to-back:** issue 100/7 and 9/3 in the cycles when tready=1 → results 0x0000000E_00000002 at cycle 34 and 0x00000003_00000000 at cycle 68. dout_tdata stays stable in between.
- **Reset mid-operation:**
  - pull reset low in cycle 17 of an operation → dout_tvalid never pulses, dout_tdata = 0, tready returns to 1 after reset is released;
  - a fresh 7/2 then completes in 34 cycles.

Source files
------------

// File: rtl/radix2_div.sv
// rtl/radix2_div.sv - iterative radix-2 restoring divider behind dividend/divisor/dout streams
module radix2_div #(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    output logic                 m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dbz;
    logic [WIDTH-1:0] abs_dvs, raw_dvd, prem, qs;
    logic             ready, accept, last_iter;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] abs_dvd_in, abs_dvs_in;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Ready is held low while reset is asserted so nothing is accepted during reset.
    assign ready                  = (state == IDLE) && reset;
    assign s_axis_dividend_tready = ready;
    assign s_axis_divisor_tready  = ready;
    assign accept    = ready && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Magnitudes are taken modulo 2^WIDTH, so the most negative value maps onto itself.
    assign dvd_neg    = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
    assign dvs_neg    = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
    assign abs_dvd_in = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign abs_dvs_in = dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

    // One restoring step: bring in the next dividend bit and try subtracting the divisor.
    assign shifted = {prem, qs[WIDTH-1]};
    assign trial   = shifted - {1'b0, abs_dvs};

    // Sign fix-up; divide-by-zero overrides with all-ones quotient and the raw dividend.
    assign q_fix = dbz ? {WIDTH{1'b1}} : (neg_q ? -qs : qs);
    assign r_fix = dbz ? raw_dvd : (neg_r ? -prem : prem);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt                <= '0;
            neg_q              <= 1'b0;
            neg_r              <= 1'b0;
            dbz                <= 1'b0;
            abs_dvs            <= '0;
            raw_dvd            <= '0;
            prem               <= '0;
            qs                 <= '0;
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
        end else begin
            m_axis_dout_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                        dbz     <= (s_axis_divisor_tdata == '0);
                        abs_dvs <= abs_dvs_in;
                        raw_dvd <= s_axis_dividend_tdata;
                        qs      <= abs_dvd_in;
                        prem    <= '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (!trial[WIDTH]) begin
                        prem <= trial[WIDTH-1:0];
                        qs   <= {qs[WIDTH-2:0], 1'b1};
                    end else begin
                        prem <= shifted[WIDTH-1:0];
                        qs   <= {qs[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    m_axis_dout_tdata  <= {q_fix, r_fix};
                    m_axis_dout_tvalid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
